// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared op codes, arbiter state encoding and sensor device addresses
package sccb_pkg;

  // SCCB master op_type codes
  localparam int OP_W3 = 0;
  localparam int OP_W2 = 1;
  localparam int OP_R2 = 2;

  // 7-bit SCCB device addresses of the supported sensors
  localparam logic [6:0] DEV_OV7670 = 7'h21;
  localparam logic [6:0] DEV_OV2640 = 7'h30;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE,
    S_HOLD
  } arb_state_t;

endpackage

// File: rtl/sccb_arbiter_rr_pick.sv
// rtl/sccb_arbiter_rr_pick.sv - combinational round-robin picker, first request at or above the pointer with wrap
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  assign o_any = |i_req;

  // Scan from the pointer upward, wrapping once; the first hit wins
  always_comb begin
    int   k;
    logic found;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      k = int'(i_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!found && i_req[IDX_W'(k)]) begin
        found                 = 1'b1;
        o_grant[IDX_W'(k)]    = 1'b1;
        o_idx                 = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sccb_arbiter.sv
// rtl/sccb_arbiter.sv - round-robin arbiter with lock sharing one SCCB master port; SCCB_ARB_TIMEOUT_EN adds a busy watchdog
module sccb_arbiter
  import sccb_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int OP_W           = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [N_REQ-1:0]      i_req_valid,
  input  logic [N_REQ-1:0]      i_req_lock,
  input  logic [N_REQ*OP_W-1:0] i_req_op_type,
  input  logic [N_REQ*8-1:0]    i_req_reg,
  input  logic [N_REQ*8-1:0]    i_req_data_in,
  input  logic [N_REQ*7-1:0]    i_req_dev_addr,
  output logic [N_REQ-1:0]      o_req_ready,
  output logic [7:0]            o_req_data_out,
  output logic                  o_m_valid,
  output logic [OP_W-1:0]       o_m_op_type,
  output logic [7:0]            o_m_reg,
  output logic [7:0]            o_m_data_in,
  output logic [6:0]            o_m_dev_addr,
  input  logic                  i_m_ready,
  input  logic [7:0]            i_m_data_out,
  output logic [N_REQ-1:0]      o_grant,
  output logic                  o_timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       r_state;
  logic [N_REQ-1:0] r_grant;
  logic [IDX_W-1:0] r_gidx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic             r_m_valid;
  logic [N_REQ-1:0] r_req_ready;
  logic             r_timeout_err;
`ifdef SCCB_ARB_TIMEOUT_EN
  logic [31:0]      r_to_cnt;
`endif

  logic [N_REQ-1:0] w_pick_grant;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_any;
  logic             w_g_valid;
  logic             w_g_lock;
  logic [IDX_W-1:0] w_next_ptr;

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_pick (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_any)
  );

  assign w_g_valid  = i_req_valid[r_gidx];
  assign w_g_lock   = i_req_lock[r_gidx];
  assign w_next_ptr = (r_gidx == IDX_W'(N_REQ - 1)) ? '0 : r_gidx + 1'b1;

  assign o_m_valid      = r_m_valid;
  assign o_req_ready    = r_req_ready;
  assign o_grant        = r_grant;
  assign o_timeout_err  = r_timeout_err;
  assign o_req_data_out = i_m_data_out;

  // Forward the owner's fields to the master; the one-hot grant makes an OR-mux safe and yields 0 when free
  always_comb begin
    o_m_op_type  = '0;
    o_m_reg      = '0;
    o_m_data_in  = '0;
    o_m_dev_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_grant[i]) begin
        o_m_op_type  = o_m_op_type  | i_req_op_type[i*OP_W +: OP_W];
        o_m_reg      = o_m_reg      | i_req_reg[i*8 +: 8];
        o_m_data_in  = o_m_data_in  | i_req_data_in[i*8 +: 8];
        o_m_dev_addr = o_m_dev_addr | i_req_dev_addr[i*7 +: 7];
      end
    end
  end

  // Ownership FSM: arbitrate, run one master transaction, handshake completion, optionally hold for a locked sequence
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_m_valid     <= 1'b0;
      r_req_ready   <= '0;
      r_timeout_err <= 1'b0;
`ifdef SCCB_ARB_TIMEOUT_EN
      r_to_cnt      <= '0;
`endif
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // never start while the master is still finishing the previous op
          if (w_any && !i_m_ready) begin
            r_grant   <= w_pick_grant;
            r_gidx    <= w_pick_idx;
            r_m_valid <= 1'b1;
            r_state   <= S_BUSY;
`ifdef SCCB_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        S_BUSY: begin
          if (i_m_ready) begin
            r_m_valid   <= 1'b0;
            r_req_ready <= r_grant;
            r_state     <= S_DONE;
          end
`ifdef SCCB_ARB_TIMEOUT_EN
          else if (r_to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            // abort: no completion to the owner, lock is ignored
            r_m_valid     <= 1'b0;
            r_timeout_err <= 1'b1;
            r_grant       <= '0;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
`endif
        end
        S_DONE: begin
          if (!w_g_valid && !i_m_ready) begin
            r_req_ready <= '0;
            if (w_g_lock) begin
              r_state <= S_HOLD;
            end else begin
              r_grant  <= '0;
              r_rr_ptr <= w_next_ptr;
              r_state  <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (!w_g_valid && !w_g_lock) begin
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end else if (w_g_valid && !i_m_ready) begin
            r_m_valid <= 1'b1;
            r_state   <= S_BUSY;
`ifdef SCCB_ARB_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_arbiter.sv
// tb/tb_sccb_arbiter.sv - randomized self-checking bench for sccb_arbiter against a round-robin ownership model
module tb_sccb_arbiter;
  import sccb_pkg::*;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_lock = '0;
  logic [N*4-1:0] req_op_type;
  logic [N*8-1:0] req_reg;
  logic [N*8-1:0] req_data_in;
  logic [N*7-1:0] req_dev_addr;
  logic [N-1:0]  req_ready;
  logic [7:0]    req_data_out;
  logic          m_valid;
  logic [3:0]    m_op_type;
  logic [7:0]    m_reg;
  logic [7:0]    m_data_in;
  logic [6:0]    m_dev_addr;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data_out = '0;
  logic [N-1:0]  grant;
  logic          timeout_err;

  logic [3:0] op [N];
  logic [7:0] rg [N];
  logic [7:0] dt [N];
  logic [6:0] da [N];

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_op_type[i*4 +: 4] = op[i];
      req_reg[i*8 +: 8]     = rg[i];
      req_data_in[i*8 +: 8] = dt[i];
      req_dev_addr[i*7 +: 7] = da[i];
    end
  end

  sccb_arbiter #(.N_REQ(N), .OP_W(4), .TIMEOUT_CYCLES(100)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .i_req_lock     (req_lock),
    .i_req_op_type  (req_op_type),
    .i_req_reg      (req_reg),
    .i_req_data_in  (req_data_in),
    .i_req_dev_addr (req_dev_addr),
    .o_req_ready    (req_ready),
    .o_req_data_out (req_data_out),
    .o_m_valid      (m_valid),
    .o_m_op_type    (m_op_type),
    .o_m_reg        (m_reg),
    .o_m_data_in    (m_data_in),
    .o_m_dev_addr   (m_dev_addr),
    .i_m_ready      (m_ready),
    .i_m_data_out   (m_data_out),
    .o_grant        (grant),
    .o_timeout_err  (timeout_err)
  );

  // Spec rule: first valid requester scanning upward from the pointer, wrapping around
  function automatic int model_pick(input logic [N-1:0] mask, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (mask[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic set_fields(input int i);
    op[i] = 4'($urandom_range(0, 2));
    rg[i] = 8'($urandom);
    dt[i] = 8'($urandom);
    da[i] = ($urandom % 2) ? DEV_OV7670 : DEV_OV2640;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    m_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  // One unlocked transaction for whoever the model says wins; called at a negedge with the arbiter idle
  task automatic do_txn(input int ready_dly);
    int exp;
    logic [7:0] rd;
    logic [N-1:0] exp_g;
    exp = model_pick(req_valid, model_ptr);
    exp_g = N'(1 << exp);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1) begin errors++; $display("FAIL txn_m_valid got %b exp 1", m_valid); end
    checks++;
    if (grant !== exp_g) begin errors++; $display("FAIL txn_grant got %b exp %b", grant, exp_g); end
    checks++;
    if ({m_op_type, m_reg, m_data_in, m_dev_addr} !== {op[exp], rg[exp], dt[exp], da[exp]}) begin
      errors++;
      $display("FAIL txn_fields got %h/%h/%h/%h exp %h/%h/%h/%h", m_op_type, m_reg, m_data_in, m_dev_addr,
               op[exp], rg[exp], dt[exp], da[exp]);
    end
    repeat (ready_dly) @(negedge clk);
    rd = 8'($urandom);
    m_data_out = rd;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== exp_g || m_valid !== 1'b0 || req_data_out !== rd) begin
      errors++;
      $display("FAIL txn_done got ready=%b valid=%b data=%h exp ready=%b valid=0 data=%h",
               req_ready, m_valid, req_data_out, exp_g, rd);
    end
    req_valid[exp] = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== '0 || req_ready !== '0) begin
      errors++;
      $display("FAIL txn_release got grant=%b ready=%b exp 0/0", grant, req_ready);
    end
    model_ptr = (exp + 1) % N;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({grant, req_ready, m_valid, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_state got grant=%b ready=%b valid=%b terr=%b exp all 0", grant, req_ready, m_valid, timeout_err);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    op[0] = 4'(OP_W3); rg[0] = 8'h12; dt[0] = 8'h80; da[0] = DEV_OV7670;
    req_valid = 3'b001;
    do_txn(4);
  endtask

  task automatic test_round_robin();
    int order [6];
    do_reset();
    for (int i = 0; i < N; i++) set_fields(i);
    req_valid = 3'b111;
    for (int t = 0; t < 6; t++) begin
      order[t] = model_pick(req_valid, model_ptr);
      do_txn(int'($urandom_range(0, 3)));
      set_fields(order[t]);
      req_valid[order[t]] = 1'b1;
    end
    checks++;
    if (order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 0) begin
      errors++;
      $display("FAIL rr_order got %0d %0d %0d %0d exp 0 1 2 0", order[0], order[1], order[2], order[3]);
    end
    req_valid = '0;
  endtask

  task automatic test_lock();
    do_reset();
    set_fields(0);
    op[1] = 4'(OP_W2); rg[1] = 8'h0A; dt[1] = 8'($urandom); da[1] = DEV_OV7670;
    req_lock[1] = 1'b1;
    req_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (grant !== 3'b010 || m_valid !== 1'b1 || m_op_type !== 4'(OP_W2) || m_reg !== 8'h0A) begin
      errors++;
      $display("FAIL lock_w2 got grant=%b valid=%b op=%h reg=%h exp 010/1/1/0a", grant, m_valid, m_op_type, m_reg);
    end
    req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    m_ready = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (grant !== 3'b010 || m_valid !== 1'b0 || req_ready !== '0) begin
      errors++;
      $display("FAIL lock_hold got grant=%b valid=%b ready=%b exp 010/0/000", grant, m_valid, req_ready);
    end
    op[1] = 4'(OP_R2);
    req_valid[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 3'b010 || m_valid !== 1'b1 || m_op_type !== 4'(OP_R2)) begin
      errors++;
      $display("FAIL lock_r2 got grant=%b valid=%b op=%h exp 010/1/2", grant, m_valid, m_op_type);
    end
    m_data_out = 8'h76;
    m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b010 || req_data_out !== 8'h76) begin
      errors++;
      $display("FAIL lock_read got ready=%b data=%h exp 010/76", req_ready, req_data_out);
    end
    req_valid[1] = 1'b0;
    req_lock[1] = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 3'b001 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL lock_next got grant=%b valid=%b exp 001/1", grant, m_valid);
    end
    m_ready = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    m_ready = 1'b0;
    @(negedge clk);
    model_ptr = 1;
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_fields(2);
    req_valid = 3'b100;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (m_valid !== 1'b0 || grant !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b grant=%b exp 0/000", m_valid, grant);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    for (int i = 0; i < N; i++) set_fields(i);
    req_valid = 3'b111;
    do_txn(1);
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) set_fields(i);
    req_valid = N'($urandom_range(1, 7));
    for (int t = 0; t < 25; t++) begin
      do_txn(int'($urandom_range(0, 4)));
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && ($urandom % 2)) begin
          set_fields(i);
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) req_valid[$urandom % N] = 1'b1;
    end
    req_valid = '0;
    @(negedge clk);
  endtask

`ifdef SCCB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int busy;
    bit seen;
    do_reset();
    set_fields(0);
    set_fields(1);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid[1] = 1'b1;
    busy = 1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (timeout_err) begin seen = 1; break; end
      if (m_valid) busy++;
    end
    checks++;
    if (!seen || busy != 100) begin
      errors++;
      $display("FAIL timeout_pulse got seen=%0d busy=%0d exp 1/100", seen, busy);
    end
    checks++;
    if (m_valid !== 1'b0 || req_ready !== '0 || grant !== '0) begin
      errors++;
      $display("FAIL timeout_abort got valid=%b ready=%b grant=%b exp 0/000/000", m_valid, req_ready, grant);
    end
    @(negedge clk);
    checks++;
    if (grant !== 3'b010 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_next got grant=%b terr=%b exp 010/0", grant, timeout_err);
    end
    do_reset();
  endtask
`endif

  initial begin
    for (int i = 0; i < N; i++) set_fields(i);
    test_reset();
    test_single();
    test_round_robin();
    test_lock();
    test_reset_busy();
    test_back_to_back();
`ifdef SCCB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
